// File: rtl/spi_slave_rx.sv
// SPI receive slave: synchronises sync_clock/CS/MOSI onto clock and shifts in one DATA_W-bit frame, LSB first.
// Optional saturating frame-error counter on err_count, enabled by defining SPI_RX_ERR_CNT_EN.
module spi_slave_rx #(
  parameter int DATA_W      = 12,
  parameter int SYNC_STAGES = 2,
  parameter bit SAMPLE_FALL = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              sync_clock,
  input  logic              CS,
  input  logic              MOSI,
  output logic [DATA_W-1:0] dout,
  output logic              done,
  output logic              frame_err,
`ifdef SPI_RX_ERR_CNT_EN
  output logic [7:0]        err_count,
`endif
  output logic              busy
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {IDLE, RECV, WAIT_CS} state_t;

  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   r_sclk_d;

  state_t            r_state;
  logic [CNT_W-1:0]  r_bit_cnt;
  logic [DATA_W-2:0] r_shreg;
  logic [DATA_W-1:0] r_dout;
  logic              r_done;
  logic              r_frame_err;

  logic              w_sclk_s;
  logic              w_cs_s;
  logic              w_mosi_s;
  logic              w_sample_edge;
  logic [DATA_W-1:0] w_shift_in;

  state_t            w_state_nxt;
  logic [CNT_W-1:0]  w_bit_cnt_nxt;
  logic [DATA_W-2:0] w_shreg_nxt;
  logic [DATA_W-1:0] w_dout_nxt;
  logic              w_done;
  logic              w_frame_err;

  // CS chain resets high so an idle bus is never mistaken for a frame start.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sclk_sync <= '0;
      r_cs_sync   <= '1;
      r_mosi_sync <= '0;
      r_sclk_d    <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sync_clock};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], CS};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], MOSI};
      r_sclk_d    <= w_sclk_s;
    end
  end

  assign w_sclk_s      = r_sclk_sync[SYNC_STAGES-1];
  assign w_cs_s        = r_cs_sync[SYNC_STAGES-1];
  assign w_mosi_s      = r_mosi_sync[SYNC_STAGES-1];
  assign w_sample_edge = SAMPLE_FALL ? (r_sclk_d & ~w_sclk_s) : (~r_sclk_d & w_sclk_s);
  // Shift register holds only the upper DATA_W-1 bits; the final word is completed combinationally.
  assign w_shift_in    = {w_mosi_s, r_shreg};

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt   = r_state;
    w_bit_cnt_nxt = r_bit_cnt;
    w_shreg_nxt   = r_shreg;
    w_dout_nxt    = r_dout;
    w_done        = 1'b0;
    w_frame_err   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (!w_cs_s) begin
          w_state_nxt   = RECV;
          w_bit_cnt_nxt = '0;
        end
      end
      RECV: begin
        if (w_cs_s) begin
          // CS deassertion outranks a coincident sampling edge.
          w_frame_err = (r_bit_cnt != '0);
          w_state_nxt = IDLE;
        end else if (w_sample_edge) begin
          w_shreg_nxt   = w_shift_in[DATA_W-1:1];
          w_bit_cnt_nxt = r_bit_cnt + CNT_W'(1);
          if (r_bit_cnt == CNT_W'(DATA_W - 1)) begin
            w_dout_nxt  = w_shift_in;
            w_done      = 1'b1;
            w_state_nxt = WAIT_CS;
          end
        end
      end
      WAIT_CS: begin
        if (w_cs_s) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_bit_cnt   <= '0;
      r_shreg     <= '0;
      r_dout      <= '0;
      r_done      <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_bit_cnt   <= w_bit_cnt_nxt;
      r_shreg     <= w_shreg_nxt;
      r_dout      <= w_dout_nxt;
      r_done      <= w_done;
      r_frame_err <= w_frame_err;
    end
  end

  assign dout      = r_dout;
  assign done      = r_done;
  assign frame_err = r_frame_err;
  assign busy      = (r_state != IDLE);

`ifdef SPI_RX_ERR_CNT_EN
  logic [7:0] r_err_cnt;

  // Counts in step with the frame_err pulse and sticks at all-ones.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_err_cnt <= 8'h00;
    end else if (w_frame_err && (r_err_cnt != 8'hFF)) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign err_count = r_err_cnt;
`endif

endmodule
